// File: rtl/scan_sequencer_pkg.sv
// Shared constants for the display scan sequencer.
//   NUM_DIGITS : number of scanned digits
//   SEL_W      : width of the digit index
//   PRESCALE_W : widest dwell divider supported (CLK_DIV up to 2^PRESCALE_W)
package scan_sequencer_pkg;
  localparam int NUM_DIGITS = 4;
  localparam int SEL_W      = 2;
  localparam int PRESCALE_W = 20;
endpackage

// File: rtl/scan_sequencer_tick_gen.sv
// Dwell prescaler. Counts enabled cycles 0..CLK_DIV-1 and wraps.
// The count holds while en is low.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, clears the count
//   en   : count enable
//   tick : combinational terminal-count strobe (en=1 and count=CLK_DIV-1);
//          the parent registers it, so the registered tick and the digit
//          update land on the same edge.
module tick_gen #(
  parameter int CLK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] count;

  assign tick = en && (count == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= tick ? '0 : count + 1'b1;
    end
  end
endmodule

// File: rtl/scan_sequencer.sv
// Multiplexed display digit scanner.
// Dwells CLK_DIV enabled cycles on each digit, then steps to the next digit
// whose mask bit is set (searching forward with wrap, current digit last).
//   clk         : clock, rising edge
//   rst         : synchronous active-high reset (sel=0, strobes cleared)
//   en          : scan enable; everything holds while low
//   digit_mask  : bit i set = digit i takes part in the scan
//   sel         : registered current digit index
//   sel_valid   : combinational digit_mask[sel]
//   tick        : registered one-cycle dwell-end strobe
//   frame_start : registered one-cycle pulse when sel wraps (new <= old)
//
// Handshake: there is none; en is a level-sensitive qualifier and all
// outputs are strobes or levels valid every cycle.
module scan_sequencer
  import scan_sequencer_pkg::*;
#(
  parameter int CLK_DIV = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [3:0]       digit_mask,
  output logic [SEL_W-1:0] sel,
  output logic             sel_valid,
  output logic             tick,
  output logic             frame_start
);
  logic             dwell_end;
  logic             found;
  logic [SEL_W-1:0] next_sel;
  logic [SEL_W-1:0] cand;

  tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (dwell_end)
  );

  // Forward search sel+1, sel+2, sel+3, then sel itself.
  always_comb begin
    next_sel = sel;
    found    = 1'b0;
    cand     = '0;
    for (int k = 1; k <= NUM_DIGITS; k++) begin
      cand = sel + SEL_W'(k);
      if (!found && digit_mask[cand]) begin
        found    = 1'b1;
        next_sel = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel         <= '0;
      tick        <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      tick        <= dwell_end;
      frame_start <= 1'b0;
      // An all-zero mask leaves sel parked and suppresses the frame pulse.
      if (dwell_end && found) begin
        sel         <= next_sel;
        frame_start <= (next_sel <= sel);
      end
    end
  end

  assign sel_valid = digit_mask[sel];
endmodule

// File: tb/tb_scan_sequencer.sv
module tb_scan_sequencer;
  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [3:0] mask_a = 4'hF;
  logic [3:0] mask_b = 4'hF;

  logic [1:0] sel_a, sel_b;
  logic       valid_a, valid_b, tick_a, tick_b, fs_a, fs_b;

  scan_sequencer #(.CLK_DIV(4)) dut_a (
    .clk(clk), .rst(rst), .en(en), .digit_mask(mask_a),
    .sel(sel_a), .sel_valid(valid_a), .tick(tick_a), .frame_start(fs_a)
  );

  scan_sequencer #(.CLK_DIV(1)) dut_b (
    .clk(clk), .rst(rst), .en(en), .digit_mask(mask_b),
    .sel(sel_b), .sel_valid(valid_b), .tick(tick_b), .frame_start(fs_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model ----------------
  // Dwell counter as a plain integer; next digit found by scanning offsets.
  int cnt_a = 0, msel_a = 0, cnt_b = 0, msel_b = 0;
  bit mtick_a = 0, mfs_a = 0, mtick_b = 0, mfs_b = 0;

  task automatic model_step(input int div, input logic [3:0] m,
                            inout int cnt, inout int s,
                            output bit t, output bit f);
    bit term;
    t = 0;
    f = 0;
    if (rst) begin
      cnt = 0;
      s   = 0;
    end else begin
      term = en && (cnt == div - 1);
      if (en) cnt = (cnt + 1) % div;
      if (term) begin
        t = 1;
        if (m != 4'b0000) begin
          for (int d = 1; d <= 4; d++) begin
            int c;
            c = (s + d) % 4;
            if (m[c]) begin
              f = (c <= s);
              s = c;
              break;
            end
          end
        end
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // One clock: model advances on the edge, outputs compared 1ns later.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_step(4, mask_a, cnt_a, msel_a, mtick_a, mfs_a);
    model_step(1, mask_b, cnt_b, msel_b, mtick_b, mfs_b);
    #1;
    check({tag, " a.sel"},   int'(sel_a),   msel_a);
    check({tag, " a.tick"},  int'(tick_a),  int'(mtick_a));
    check({tag, " a.fs"},    int'(fs_a),    int'(mfs_a));
    check({tag, " a.valid"}, int'(valid_a), int'(mask_a[msel_a[1:0]]));
    check({tag, " b.sel"},   int'(sel_b),   msel_b);
    check({tag, " b.tick"},  int'(tick_b),  int'(mtick_b));
    check({tag, " b.fs"},    int'(fs_b),    int'(mfs_b));
    check({tag, " b.valid"}, int'(valid_b), int'(mask_b[msel_b[1:0]]));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] mask;
    int         sel;
    logic       tick;
    logic       fs;
    logic       valid;
    int         reps;
  } vec_t;

  vec_t vecs[$];

  initial begin
    // full rotation, mask 1111
    vecs.push_back('{1, 0, 4'hF, 0, 0, 0, 1, 1});
    vecs.push_back('{0, 1, 4'hF, 0, 0, 0, 1, 3});
    vecs.push_back('{0, 1, 4'hF, 1, 1, 0, 1, 1});
    vecs.push_back('{0, 1, 4'hF, 1, 0, 0, 1, 3});
    vecs.push_back('{0, 1, 4'hF, 2, 1, 0, 1, 1});
    vecs.push_back('{0, 1, 4'hF, 2, 0, 0, 1, 3});
    vecs.push_back('{0, 1, 4'hF, 3, 1, 0, 1, 1});
    vecs.push_back('{0, 1, 4'hF, 3, 0, 0, 1, 3});
    vecs.push_back('{0, 1, 4'hF, 0, 1, 1, 1, 1});
    // mask 1010: 0 -> 1 -> 3 -> 1 -> 3
    vecs.push_back('{1, 0, 4'hA, 0, 0, 0, 0, 1});
    vecs.push_back('{0, 1, 4'hA, 0, 0, 0, 0, 3});
    vecs.push_back('{0, 1, 4'hA, 1, 1, 0, 1, 1});
    vecs.push_back('{0, 1, 4'hA, 1, 0, 0, 1, 3});
    vecs.push_back('{0, 1, 4'hA, 3, 1, 0, 1, 1});
    vecs.push_back('{0, 1, 4'hA, 3, 0, 0, 1, 3});
    vecs.push_back('{0, 1, 4'hA, 1, 1, 1, 1, 1});
    vecs.push_back('{0, 1, 4'hA, 1, 0, 0, 1, 3});
    vecs.push_back('{0, 1, 4'hA, 3, 1, 0, 1, 1});
    // mask 0100 then 0000: 0 -> 2 (no wrap), 2 -> 2 wraps, then park
    vecs.push_back('{1, 0, 4'h4, 0, 0, 0, 0, 1});
    vecs.push_back('{0, 1, 4'h4, 0, 0, 0, 0, 3});
    vecs.push_back('{0, 1, 4'h4, 2, 1, 0, 1, 1});
    vecs.push_back('{0, 1, 4'h4, 2, 0, 0, 1, 3});
    vecs.push_back('{0, 1, 4'h4, 2, 1, 1, 1, 1});
    vecs.push_back('{0, 1, 4'h0, 2, 0, 0, 0, 3});
    vecs.push_back('{0, 1, 4'h0, 2, 1, 0, 0, 1});
    // en gap of 5 cycles with count at terminal
    vecs.push_back('{1, 0, 4'hF, 0, 0, 0, 1, 1});
    vecs.push_back('{0, 1, 4'hF, 0, 0, 0, 1, 3});
    vecs.push_back('{0, 0, 4'hF, 0, 0, 0, 1, 5});
    vecs.push_back('{0, 1, 4'hF, 1, 1, 0, 1, 1});
    // reset at count=2 while sel=3
    vecs.push_back('{1, 0, 4'hF, 0, 0, 0, 1, 1});
    vecs.push_back('{0, 1, 4'hF, 0, 0, 0, 1, 3});
    vecs.push_back('{0, 1, 4'hF, 1, 1, 0, 1, 1});
    vecs.push_back('{0, 1, 4'hF, 1, 0, 0, 1, 3});
    vecs.push_back('{0, 1, 4'hF, 2, 1, 0, 1, 1});
    vecs.push_back('{0, 1, 4'hF, 2, 0, 0, 1, 3});
    vecs.push_back('{0, 1, 4'hF, 3, 1, 0, 1, 1});
    vecs.push_back('{0, 1, 4'hF, 3, 0, 0, 1, 2});
    vecs.push_back('{1, 1, 4'hF, 0, 0, 0, 1, 1});
    vecs.push_back('{0, 1, 4'hF, 0, 0, 0, 1, 3});
    vecs.push_back('{0, 1, 4'hF, 1, 1, 0, 1, 1});
  end

  // ---------------- driver ----------------
  initial begin
    #1;
    foreach (vecs[i]) begin
      rst    = vecs[i].rst;
      en     = vecs[i].en;
      mask_a = vecs[i].mask;
      mask_b = 4'hF;
      for (int r = 0; r < vecs[i].reps; r++) begin
        cycle($sformatf("vec%0d", i));
        check($sformatf("vec%0d.sel", i),   int'(sel_a),   vecs[i].sel);
        check($sformatf("vec%0d.tick", i),  int'(tick_a),  int'(vecs[i].tick));
        check($sformatf("vec%0d.fs", i),    int'(fs_a),    int'(vecs[i].fs));
        check($sformatf("vec%0d.valid", i), int'(valid_a), int'(vecs[i].valid));
      end
    end

    // CLK_DIV=1: advance every cycle, then collapse to digit 0 only
    rst = 1'b1; en = 1'b0; mask_b = 4'hF;
    cycle("div1 rst");
    rst = 1'b0; en = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      cycle("div1 run");
      check("div1.tick", int'(tick_b), 1);
      check("div1.sel",  int'(sel_b),  k % 4);
    end
    mask_b = 4'b0001;
    cycle("div1 mask");
    check("div1.mask sel", int'(sel_b), 0);
    check("div1.mask fs",  int'(fs_b),  1);

    // randomized run against the model
    for (int i = 0; i < 400; i++) begin
      rst    = ($urandom_range(0, 39) == 0);
      en     = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) mask_a = 4'($urandom_range(0, 15));
      mask_b = 4'($urandom_range(0, 15));
      cycle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
